alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Parametrised, registered ALU execution unit for the MIPS datapath: decodes the 3-bit ALUOp and the R-format funct field and executes the operation. It keeps the existing ALU control encoding and extends it with variable shifts, unsigned variants, and iterative multiply/divide into HI/LO registers. Operands arrive over a valid/ready handshake. Results leave as a registered one-cycle `out_valid` pulse, ready for a multi-cycle or pipelined core.

## Interface
- `WIDTH`, 32: operand/result width; even, ≥8.
- `SH_W`, $clog2(WIDTH): shift-amount width (derived; not overridden).

- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  operation request
- `in_ready`  out  1  unit can accept a request this cycle
- `alu_op`  in  3  ALUOp from control unit
- `funct`  in  6  Instruction[5:0]
- `shamt`  in  SH_W  fixed shift amount (Instruction[10:6] truncated/extended)
- `a`, `b`  in  WIDTH  rs / rt operands
- `out_valid`  out  1  one-cycle result strobe
- `result`  out  WIDTH  registered result
- `zero`  out  1  result == 0, registered with `result`
- `ovf`  out  1  signed overflow (ADD/SUB funct only)
- `illegal`  out  1  unknown funct with alu_op=010
- `hi`, `lo`  out  WIDTH  architectural HI/LO registers

## Operation
- Accept when `in_valid && in_ready`; inputs sampled only then.
- alu_op: 000 add; 001 sub; 010 R-format (decode funct); 011 and; 100 or; 101 xor; 110 b << (WIDTH/2); 111 signed slt.
- funct, single-cycle ops:
  - shifts: 000000 sll, 000010 srl, 000011 sra by `shamt`; 000100 sllv, 000110 srlv, 000111 srav by a[SH_W-1:0], shifting b.
  - arithmetic: 100000 add, 100001 addu, 100010 sub, 100011 subu.
  - logic: 100100 and, 100101 or, 100110 xor, 100111 nor.
  - compare: 101010 slt (signed), 101011 sltu.
  - HI/LO reads: 010000 mfhi, 010010 mflo.
- funct, multi-cycle ops (HI/LO only): 011000 mult, 011001 multu, 011010 div, 011011 divu.
- Arithmetic is modulo 2^WIDTH. `ovf` = 1 only for funct add/sub, when operand signs agree (add) or differ (sub) and the result sign differs from `a`; the result is still written. addu/subu and alu_op 000/001 never set `ovf`.
- SLT/SLTU result is 0 or 1, zero-extended.
- Unknown funct under 010: result 0, `illegal`=1, `out_valid`=1, HI/LO unchanged.
- State machine IDLE → MUL or DIV → FIX → IDLE.
  - IDLE: `in_ready`=1. Single-cycle ops stay in IDLE; mult/multu go to MUL; div/divu go to DIV.
  - MUL: unsigned shift-add on operand magnitudes, one bit per cycle, WIDTH cycles.
  - DIV: restoring division on magnitudes, one bit per cycle, WIDTH cycles.
  - FIX: applies signs, writes HI/LO, pulses `out_valid` with `result`=new LO; returns to IDLE.
- mult: {HI,LO} = full 2·WIDTH product.
- div:
  - LO = quotient, truncated toward zero; HI = remainder, carrying the sign of the dividend.
  - Divide by zero: LO = all-ones, HI = a; full latency still applies; no flag.
  - Signed most-negative / −1: LO = most-negative, HI = 0.
- `in_ready`=0 in MUL, DIV and FIX.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `result`=0, `zero`=0, `ovf`=0, `illegal`=0, `hi`=0, `lo`=0, state=IDLE.
- Single-cycle ops:
  - Accepted at edge E0; `out_valid`, `result` and flags are visible after E0, for one cycle.
  - Back-to-back accepts give one result per cycle.
- Multi-cycle ops:
  - Accepted at E0; iterations on E1..E_WIDTH; FIX at E_(WIDTH+1).
  - `out_valid` and the new HI/LO are visible after E_(WIDTH+1); `in_ready` returns to 1 in that same cycle.
  - Latency WIDTH+1 cycles; 33 for WIDTH=32.
- mfhi/mflo accepted in the same cycle as the FIX completion read the new values, because the request is sampled after the FIX edge.
- Flags (`zero`, `ovf`, `illegal`) are meaningful only while `out_valid`=1 and are 0 otherwise.
- `rst` mid-operation aborts: state=IDLE, HI/LO cleared, no `out_valid`.
- `in_valid` while `in_ready`=0 is ignored; inputs are not queued.

## Test plan
- Reset, then add with a=0x7FFFFFFF, b=1 (alu_op=010, funct=100000) → after one edge: result=0x80000000, `ovf`=1, `zero`=0. addu with the same operands → `ovf`=0.
- Back-to-back ops on consecutive cycles, each with `out_valid`=1 on the following cycle and no gaps:
  - srav, a=4, b=0xF0000000 → 0xFF000000
  - sltu, a=1, b=0xFFFFFFFF → 1
  - slt with the same a, b → 0
  - alu_op=110, b=0x1234 → 0x12340000
- mult a=0xFFFFFFFE (−2), b=3 → HI=0xFFFFFFFF, LO=0xFFFFFFFA after exactly 33 cycles. `in_ready`=0 for 33 cycles; a request presented while busy is dropped; mfhi issued next returns 0xFFFFFFFF.
- div a=−7, b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu a=7, b=0 → LO=0xFFFFFFFF, HI=7 after 33 cycles.
- Assert `rst` 10 cycles into a div → next cycle `in_ready`=1, HI=LO=0, no `out_valid`. Unknown funct 111111 → `illegal`=1, result=0, HI/LO unchanged.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Registered MIPS ALU execution unit: single-cycle ALU ops plus iterative mult/div into HI/LO.
module alu_exec_unit #(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned SH_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [SH_W-1:0]  shamt,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             illegal,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned DW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t           state, state_d;
  logic [SH_W-1:0]  cnt, cnt_d;
  logic [DW-1:0]    acc, acc_d;      // mul: {partial, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0] opnd, opnd_d;    // multiplicand or divisor magnitude
  logic [WIDTH-1:0] a_sv, a_sv_d;    // dividend kept for the divide-by-zero HI value
  logic             is_div, is_div_d;
  logic             neg_q, neg_q_d;  // negate product / quotient in FIX
  logic             neg_r, neg_r_d;  // negate remainder in FIX
  logic             div0, div0_d;

  logic             in_ready_d, out_valid_d, zero_d, ovf_d, illegal_d;
  logic [WIDTH-1:0] result_d, hi_d, lo_d;

  logic             accept;
  logic             signed_md;
  logic [WIDTH-1:0] sum, diff, mag_a, mag_b;
  logic [WIDTH:0]   mul_sum, div_trial;
  logic [DW-1:0]    prod_fix;
  logic [WIDTH-1:0] q_fix, r_fix;
  logic             slt_s, slt_u;

  logic [WIDTH-1:0] res_c;
  logic             ovf_c, ill_c, single_c;

  // Shared datapath terms for decode and iteration
  assign accept    = in_valid & in_ready;
  assign signed_md = ~funct[0];
  assign sum       = a + b;
  assign diff      = a - b;
  assign slt_s     = $signed(a) < $signed(b);
  assign slt_u     = a < b;
  assign mag_a     = (signed_md && a[WIDTH-1]) ? -a : a;
  assign mag_b     = (signed_md && b[WIDTH-1]) ? -b : b;
  assign mul_sum   = {1'b0, acc[DW-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
  assign div_trial = {acc[DW-1:WIDTH], acc[WIDTH-1]} - {1'b0, opnd};
  assign prod_fix  = neg_q ? -acc : acc;
  assign q_fix     = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign r_fix     = neg_r ? -acc[DW-1:WIDTH] : acc[DW-1:WIDTH];

  // Next-state, datapath and output decode
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    acc_d       = acc;
    opnd_d      = opnd;
    a_sv_d      = a_sv;
    is_div_d    = is_div;
    neg_q_d     = neg_q;
    neg_r_d     = neg_r;
    div0_d      = div0;
    out_valid_d = 1'b0;
    zero_d      = 1'b0;
    ovf_d       = 1'b0;
    illegal_d   = 1'b0;
    result_d    = result;
    hi_d        = hi;
    lo_d        = lo;
    res_c       = '0;
    ovf_c       = 1'b0;
    ill_c       = 1'b0;
    single_c    = 1'b1;

    case (state)
      IDLE: begin
        if (accept) begin
          case (alu_op)
            3'b000: res_c = sum;
            3'b001: res_c = diff;
            3'b011: res_c = a & b;
            3'b100: res_c = a | b;
            3'b101: res_c = a ^ b;
            3'b110: res_c = b << (WIDTH / 2);
            3'b111: res_c = {{(WIDTH-1){1'b0}}, slt_s};
            default: begin
              case (funct)
                6'b000000: res_c = b << shamt;
                6'b000010: res_c = b >> shamt;
                6'b000011: res_c = WIDTH'($signed(b) >>> shamt);
                6'b000100: res_c = b << a[SH_W-1:0];
                6'b000110: res_c = b >> a[SH_W-1:0];
                6'b000111: res_c = WIDTH'($signed(b) >>> a[SH_W-1:0]);
                6'b100000: begin
                  res_c = sum;
                  ovf_c = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
                end
                6'b100001: res_c = sum;
                6'b100010: begin
                  res_c = diff;
                  ovf_c = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
                end
                6'b100011: res_c = diff;
                6'b100100: res_c = a & b;
                6'b100101: res_c = a | b;
                6'b100110: res_c = a ^ b;
                6'b100111: res_c = ~(a | b);
                6'b101010: res_c = {{(WIDTH-1){1'b0}}, slt_s};
                6'b101011: res_c = {{(WIDTH-1){1'b0}}, slt_u};
                6'b010000: res_c = hi;
                6'b010010: res_c = lo;
                6'b011000, 6'b011001: begin
                  single_c = 1'b0;
                  state_d  = MUL;
                  cnt_d    = '0;
                  acc_d    = {{WIDTH{1'b0}}, mag_b};
                  opnd_d   = mag_a;
                  is_div_d = 1'b0;
                  neg_q_d  = signed_md & (a[WIDTH-1] ^ b[WIDTH-1]);
                  neg_r_d  = 1'b0;
                  div0_d   = 1'b0;
                end
                6'b011010, 6'b011011: begin
                  single_c = 1'b0;
                  state_d  = DIV;
                  cnt_d    = '0;
                  acc_d    = {{WIDTH{1'b0}}, mag_a};
                  opnd_d   = mag_b;
                  a_sv_d   = a;
                  is_div_d = 1'b1;
                  neg_q_d  = signed_md & (a[WIDTH-1] ^ b[WIDTH-1]);
                  neg_r_d  = signed_md & a[WIDTH-1];
                  div0_d   = (b == '0);
                end
                default: ill_c = 1'b1;
              endcase
            end
          endcase
          if (single_c) begin
            out_valid_d = 1'b1;
            result_d    = res_c;
            zero_d      = (res_c == '0);
            ovf_d       = ovf_c;
            illegal_d   = ill_c;
          end
        end
      end
      MUL: begin
        acc_d = {mul_sum, acc[WIDTH-1:1]};
        cnt_d = cnt + SH_W'(1);
        if (cnt == SH_W'(WIDTH - 1)) state_d = FIX;
      end
      DIV: begin
        if (!div_trial[WIDTH]) acc_d = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else                   acc_d = {acc[DW-2:0], 1'b0};
        cnt_d = cnt + SH_W'(1);
        if (cnt == SH_W'(WIDTH - 1)) state_d = FIX;
      end
      default: begin
        state_d = IDLE;
        if (!is_div) begin
          hi_d = prod_fix[DW-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (div0) begin
          hi_d = a_sv;
          lo_d = '1;
        end else begin
          hi_d = r_fix;
          lo_d = q_fix;
        end
        out_valid_d = 1'b1;
        result_d    = lo_d;
        zero_d      = (lo_d == '0);
      end
    endcase

    in_ready_d = (state_d == IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      opnd      <= '0;
      a_sv      <= '0;
      is_div    <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      div0      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
      illegal   <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      acc       <= acc_d;
      opnd      <= opnd_d;
      a_sv      <= a_sv_d;
      is_div    <= is_div_d;
      neg_q     <= neg_q_d;
      neg_r     <= neg_r_d;
      div0      <= div0_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      result    <= result_d;
      zero      <= zero_d;
      ovf       <= ovf_d;
      illegal   <= illegal_d;
      hi        <= hi_d;
      lo        <= lo_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit (WIDTH=32).
module tb_alu_exec_unit;

  localparam int unsigned W = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  alu_op = '0;
  logic [5:0]  funct = '0;
  logic [4:0]  shamt = '0;
  logic [W-1:0] a = '0, b = '0;
  logic        out_valid;
  logic [W-1:0] result;
  logic        zero, ovf, illegal;
  logic [W-1:0] hi, lo;

  int total = 0;
  int bad = 0;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct(funct), .shamt(shamt), .a(a), .b(b),
    .out_valid(out_valid), .result(result), .zero(zero), .ovf(ovf),
    .illegal(illegal), .hi(hi), .lo(lo)
  );

  // 10-unit clock
  always #5 clk = ~clk;

  // Safety net against a hung run
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [5:0] f, input logic [4:0] sh,
                       input logic [W-1:0] ia, input logic [W-1:0] ib);
    alu_op   = op;
    funct    = f;
    shamt    = sh;
    a        = ia;
    b        = ib;
    in_valid = 1'b1;
  endtask

  // Single-cycle op: accept on the next edge, check the registered result right after it
  task automatic alu1(input string tag, input logic [2:0] op, input logic [5:0] f,
                      input logic [4:0] sh, input logic [W-1:0] ia, input logic [W-1:0] ib,
                      input logic [W-1:0] eres, input logic eovf);
    drive(op, f, sh, ia, ib);
    step();
    in_valid = 1'b0;
    chk({tag, ".valid"}, 64'(out_valid), 64'd1);
    chk({tag, ".result"}, 64'(result), 64'(eres));
    chk({tag, ".ovf"}, 64'(ovf), 64'(eovf));
  endtask

  // Multi-cycle op: checks latency, busy window, HI/LO and result; optionally pokes a request while busy
  task automatic run_md(input string tag, input logic [5:0] f, input logic [W-1:0] ia,
                        input logic [W-1:0] ib, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                        input bit poke);
    int cyc;
    int busy;
    drive(3'b010, f, 5'd0, ia, ib);
    step();
    in_valid = 1'b0;
    cyc = 0;
    busy = 0;
    while (!out_valid && cyc < 100) begin
      if (!in_ready) busy++;
      if (poke && cyc == 1) drive(3'b010, 6'b100000, 5'd0, 32'd1, 32'd1);
      if (poke && cyc == 4) in_valid = 1'b0;
      step();
      cyc++;
    end
    in_valid = 1'b0;
    chk({tag, ".latency"}, 64'(cyc), 64'd33);
    chk({tag, ".busy"}, 64'(busy), 64'd33);
    chk({tag, ".hi"}, 64'(hi), 64'(ehi));
    chk({tag, ".lo"}, 64'(lo), 64'(elo));
    chk({tag, ".result"}, 64'(result), 64'(elo));
    chk({tag, ".ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int seen;

    // Reset
    repeat (2) step();
    rst = 1'b0;
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.result", 64'(result), 64'd0);
    chk("rst.flags", 64'({zero, ovf, illegal}), 64'd0);
    chk("rst.hi", 64'(hi), 64'd0);
    chk("rst.lo", 64'(lo), 64'd0);

    // Signed overflow on add; addu never flags
    alu1("add_ovf", 3'b010, 6'b100000, 5'd0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b1);
    chk("add_ovf.zero", 64'(zero), 64'd0);
    alu1("addu", 3'b010, 6'b100001, 5'd0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0);
    step();
    chk("idle.out_valid", 64'(out_valid), 64'd0);
    chk("idle.ovf", 64'(ovf), 64'd0);

    // Back-to-back ops, one result per cycle
    drive(3'b010, 6'b000111, 5'd0, 32'd4, 32'hF000_0000);
    step();
    chk("srav.valid", 64'(out_valid), 64'd1);
    chk("srav.result", 64'(result), 64'hFF00_0000);
    drive(3'b010, 6'b101011, 5'd0, 32'd1, 32'hFFFF_FFFF);
    step();
    chk("sltu.valid", 64'(out_valid), 64'd1);
    chk("sltu.result", 64'(result), 64'd1);
    drive(3'b010, 6'b101010, 5'd0, 32'd1, 32'hFFFF_FFFF);
    step();
    chk("slt.valid", 64'(out_valid), 64'd1);
    chk("slt.result", 64'(result), 64'd0);
    chk("slt.zero", 64'(zero), 64'd1);
    drive(3'b110, 6'b000000, 5'd0, 32'd0, 32'h0000_1234);
    step();
    in_valid = 1'b0;
    chk("lui.valid", 64'(out_valid), 64'd1);
    chk("lui.result", 64'(result), 64'h1234_0000);

    // Further single-cycle patterns
    alu1("sub_ovf", 3'b010, 6'b100010, 5'd0, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b1);
    alu1("op_sub", 3'b001, 6'b000000, 5'd0, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0);
    alu1("nor", 3'b010, 6'b100111, 5'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0);
    alu1("sll", 3'b010, 6'b000000, 5'd4, 32'd0, 32'd1, 32'h0000_0010, 1'b0);
    alu1("sra", 3'b010, 6'b000011, 5'd4, 32'd0, 32'h8000_0000, 32'hF800_0000, 1'b0);
    alu1("srl31", 3'b010, 6'b000010, 5'd31, 32'd0, 32'h8000_0000, 32'd1, 1'b0);
    alu1("op_slt", 3'b111, 6'b000000, 5'd0, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);

    // mult -2 * 3 with a request dropped while busy, then mfhi/mflo right after completion
    run_md("mult", 6'b011000, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b1);
    alu1("mfhi", 3'b010, 6'b010000, 5'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0);
    alu1("mflo", 3'b010, 6'b010010, 5'd0, 32'd0, 32'd0, 32'hFFFF_FFFA, 1'b0);

    // Division cases
    run_md("div", 6'b011010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_md("div_minneg", 6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
    run_md("multu", 6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 1'b0);
    run_md("divu0", 6'b011011, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 1'b0);
    step();
    chk("divu0.pulse", 64'(out_valid), 64'd0);

    // Reset ten cycles into a divide aborts it and clears HI/LO
    drive(3'b010, 6'b011010, 5'd0, 32'd100, 32'd3);
    step();
    in_valid = 1'b0;
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort.in_ready", 64'(in_ready), 64'd1);
    chk("abort.hi", 64'(hi), 64'd0);
    chk("abort.lo", 64'(lo), 64'd0);
    chk("abort.out_valid", 64'(out_valid), 64'd0);
    seen = 0;
    repeat (40) begin
      step();
      if (out_valid) seen++;
    end
    chk("abort.no_result", 64'(seen), 64'd0);

    // Unknown funct leaves HI/LO alone
    run_md("mult_pre", 6'b011000, 32'h0001_0000, 32'h0003_0000, 32'd3, 32'd0, 1'b0);
    drive(3'b010, 6'b111111, 5'd0, 32'h1234_5678, 32'h9ABC_DEF0);
    step();
    in_valid = 1'b0;
    chk("illegal.valid", 64'(out_valid), 64'd1);
    chk("illegal.flag", 64'(illegal), 64'd1);
    chk("illegal.result", 64'(result), 64'd0);
    chk("illegal.hi", 64'(hi), 64'd3);
    chk("illegal.lo", 64'(lo), 64'd0);
    step();
    chk("illegal.clear", 64'(illegal), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
